// File: rtl/alu_pkg.sv
// Shared ALU opcode, latency-class and sequencer state encodings.
package alu_pkg;

  localparam logic [5:0] ALU_ADD    = 6'd0;
  localparam logic [5:0] ALU_MULH   = 6'd16;
  localparam logic [5:0] ALU_MULHSU = 6'd17;
  localparam logic [5:0] ALU_MULHU  = 6'd18;
  localparam logic [5:0] ALU_MUL    = 6'd22;
  localparam logic [5:0] ALU_DIV    = 6'd24;
  localparam logic [5:0] ALU_DIVU   = 6'd26;
  localparam logic [5:0] ALU_REM    = 6'd28;
  localparam logic [5:0] ALU_REMU   = 6'd30;

  // Latency class lives in aluop[4:3]; any 0x pattern is single-cycle.
  localparam logic [1:0] LC_MUL = 2'b10;
  localparam logic [1:0] LC_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; pointer flips to the other port after each accepted grant.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic gnt0,
  output logic gnt1
);

  logic ptr_q, ptr_d;

  // A lone requester always wins; on contention the pointer picks.
  assign gnt0 = req0 & (~req1 | ~ptr_q);
  assign gnt1 = req1 & (~req0 | ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = gnt0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Arbitrates two issue ports onto a shared combinational ALU, holding operands for a
// class-dependent number of cycles and returning the result over a valid/ready channel.
module alu_issue_sequencer
  import alu_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [5:0]       req0_aluop,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [5:0]       req1_aluop,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [5:0]       alu_op,
  output logic [31:0]      alu_in1,
  output logic [31:0]      alu_in2,
  input  logic [31:0]      alu_out,
  input  logic             alu_div_error,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_src,
  output logic             resp_div_error
);

  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             src_q, src_d;
  logic             rv_q, rv_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic             rsrc_q, rsrc_d;
  logic             rerr_q, rerr_d;

  logic       gnt0, gnt1, take;
  logic [5:0] sel_op;
  logic       div_err;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0_valid),
    .req1   (req1_valid),
    .accept (take),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // rst_n term keeps ready low while reset is held, even though state already reads IDLE.
  assign req0_ready = gnt0 & (state_q == IDLE) & ~flush & rst_n;
  assign req1_ready = gnt1 & (state_q == IDLE) & ~flush & rst_n;
  assign take       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign sel_op     = gnt1 ? req1_aluop : req0_aluop;
  assign div_err    = alu_div_error & (op_q[4:3] == LC_DIV);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    src_d   = src_q;
    rv_d    = rv_q;
    rdata_d = rdata_q;
    rtag_d  = rtag_q;
    rsrc_d  = rsrc_q;
    rerr_d  = rerr_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          op_d    = sel_op;
          a_d     = gnt1 ? req1_a : req0_a;
          b_d     = gnt1 ? req1_b : req0_b;
          tag_d   = gnt1 ? req1_tag : req0_tag;
          src_d   = gnt1;
          state_d = EXEC;
          if (sel_op[4:3] == LC_MUL)      cnt_d = CNT_W'(MUL_CYCLES - 1);
          else if (sel_op[4:3] == LC_DIV) cnt_d = CNT_W'(DIV_CYCLES - 1);
          else                            cnt_d = '0;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rv_d    = 1'b1;
          rerr_d  = div_err;
          rtag_d  = tag_q;
          rsrc_d  = src_q;
          // Divide-by-zero results follow the RISC-V convention rather than the ALU output.
          rdata_d = div_err ? (op_q[2] ? a_q : 32'hFFFF_FFFF) : alu_out;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      rv_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      src_q   <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      rtag_q  <= '0;
      rsrc_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      src_q   <= src_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      rtag_q  <= rtag_d;
      rsrc_q  <= rsrc_d;
      rerr_q  <= rerr_d;
    end
  end

  assign alu_op         = op_q;
  assign alu_in1        = a_q;
  assign alu_in2        = b_q;
  assign resp_valid     = rv_q;
  assign resp_data      = rdata_q;
  assign resp_tag       = rtag_q;
  assign resp_src       = rsrc_q;
  assign resp_div_error = rerr_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer with a behavioural ALU attached.
module tb_alu_issue_sequencer;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [5:0]       req0_aluop, req1_aluop;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic [5:0]       alu_op;
  logic [31:0]      alu_in1, alu_in2, alu_out;
  logic             alu_div_error;
  logic             resp_valid, resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_src, resp_div_error;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_sequencer #(.TAG_W(TAG_W), .MUL_CYCLES(2), .DIV_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_div_error(alu_div_error),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_src(resp_src), .resp_div_error(resp_div_error)
  );

  // Divide-by-zero returns a marker so the sequencer's override is visible.
  always_comb begin
    alu_out       = 32'h0;
    alu_div_error = (alu_op[4:3] == 2'b11) && (alu_in2 == 32'h0);
    case (alu_op)
      6'd0:  alu_out = alu_in1 + alu_in2;
      6'd22: alu_out = alu_in1 * alu_in2;
      6'd24: alu_out = alu_div_error ? 32'hDEAD_BEEF : $signed(alu_in1) / $signed(alu_in2);
      6'd26: alu_out = alu_div_error ? 32'hDEAD_BEEF : alu_in1 / alu_in2;
      6'd28: alu_out = alu_div_error ? 32'hDEAD_BEEF : $signed(alu_in1) % $signed(alu_in2);
      6'd30: alu_out = alu_div_error ? 32'hDEAD_BEEF : alu_in1 % alu_in2;
      default: alu_out = 32'h0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    if (p == 0) begin
      req0_valid = v; req0_aluop = op; req0_a = a; req0_b = b; req0_tag = tag;
    end else begin
      req1_valid = v; req1_aluop = op; req1_a = a; req1_b = b; req1_tag = tag;
    end
  endtask

  // Issues one op from a negedge, checks operand hold and latency, completes the handshake.
  task automatic run_op(input int p, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    int c;
    resp_ready = 1'b1;
    drive(p, 1'b1, op, a, b, tag);
    #1;
    check_eq("accept_ready", 32'(p == 0 ? req0_ready : req1_ready), 32'd1);
    @(negedge clk);
    drive(p, 1'b0, 6'd0, 32'd0, 32'd0, '0);
    check_eq("alu_op", 32'(alu_op), 32'(op));
    c = 0;
    while (!resp_valid && c < 30) begin
      check_eq("alu_in1_hold", alu_in1, a);
      check_eq("alu_in2_hold", alu_in2, b);
      @(negedge clk);
      c++;
    end
    check_eq("latency", 32'(c), 32'(exp_lat));
    check_eq("resp_data", resp_data, exp_data);
    check_eq("resp_err", 32'(resp_div_error), 32'(exp_err));
    check_eq("resp_tag", 32'(resp_tag), 32'(tag));
    check_eq("resp_src", 32'(resp_src), 32'(p));
    @(negedge clk);
    check_eq("resp_clear", 32'(resp_valid), 32'd0);
  endtask

  task automatic count_idle_resp(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
  endtask

  initial begin
    int c, seen, grants, r0, r1, both_hi;
    rst_n = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    drive(0, 1'b1, 6'd0, 32'd1, 32'd1, 4'd1);
    drive(1, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
    #2;
    check_eq("rst_ready0", 32'(req0_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_data", resp_data, 32'd0);
    check_eq("rst_alu_op", 32'(alu_op), 32'd0);
    check_eq("rst_alu_in1", alu_in1, 32'd0);
    check_eq("rst_alu_in2", alu_in2, 32'd0);
    check_eq("rst_resp_tag", 32'(resp_tag), 32'd0);
    check_eq("rst_resp_err", 32'(resp_div_error), 32'd0);
    drive(0, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle add, multicycle multiply, divide-by-zero on div and rem.
    run_op(0, 6'd0,  32'd5,   32'd7, 4'd3,  32'd12,        1'b0, 1);
    run_op(1, 6'd22, 32'd6,   32'd7, 4'd9,  32'd42,        1'b0, 2);
    run_op(0, 6'd24, 32'd100, 32'd0, 4'd4,  32'hFFFF_FFFF, 1'b1, 8);
    run_op(1, 6'd28, 32'd100, 32'd0, 4'd10, 32'd100,       1'b1, 8);
    run_op(0, 6'd30, 32'd100, 32'd7, 4'd11, 32'd2,         1'b0, 8);

    // Backpressure on a divu result while another request waits.
    resp_ready = 1'b0;
    drive(1, 1'b1, 6'd26, 32'd100, 32'd7, 4'd5);
    #1;
    check_eq("bp_accept", 32'(req1_ready), 32'd1);
    @(negedge clk);
    drive(1, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
    c = 0;
    while (!resp_valid && c < 30) begin
      @(negedge clk);
      c++;
    end
    check_eq("bp_latency", 32'(c), 32'd8);
    drive(0, 1'b1, 6'd0, 32'd1, 32'd1, 4'd6);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("bp_valid", 32'(resp_valid), 32'd1);
      check_eq("bp_data", resp_data, 32'd14);
      check_eq("bp_no_accept", 32'(req0_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    check_eq("bp_hs_data", resp_data, 32'd14);
    check_eq("bp_hs_no_accept", 32'(req0_ready), 32'd0);
    @(negedge clk);
    check_eq("bp_after_valid", 32'(resp_valid), 32'd0);
    check_eq("bp_after_ready", 32'(req0_ready), 32'd1);
    @(negedge clk);
    drive(0, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
    c = 0;
    while (!resp_valid && c < 30) begin
      @(negedge clk);
      c++;
    end
    check_eq("bp_next_lat", 32'(c), 32'd1);
    check_eq("bp_next_data", resp_data, 32'd2);
    check_eq("bp_next_tag", 32'(resp_tag), 32'd6);
    @(negedge clk);

    // Flush in the 4th EXEC cycle of a divide.
    drive(0, 1'b1, 6'd24, 32'd100, 32'd3, 4'd8);
    #1;
    check_eq("fl_accept", 32'(req0_ready), 32'd1);
    @(negedge clk);
    drive(0, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    drive(1, 1'b1, 6'd0, 32'd3, 32'd4, 4'd7);
    #1;
    check_eq("fl_ready_gated", 32'(req1_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_eq("fl_idle_ready", 32'(req1_ready), 32'd1);
    check_eq("fl_no_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    drive(1, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
    check_eq("fl_next_in1", alu_in1, 32'd3);
    @(negedge clk);
    check_eq("fl_next_valid", 32'(resp_valid), 32'd1);
    check_eq("fl_next_data", resp_data, 32'd7);
    check_eq("fl_next_tag", 32'(resp_tag), 32'd7);
    check_eq("fl_next_src", 32'(resp_src), 32'd1);
    count_idle_resp(10, seen);
    check_eq("fl_stale_resp", 32'(seen), 32'd0);
    run_op(0, 6'd0, 32'd10, 32'd20, 4'd12, 32'd30, 1'b0, 1);

    // Asynchronous reset mid-EXEC.
    drive(1, 1'b1, 6'd26, 32'd100, 32'd7, 4'd2);
    @(negedge clk);
    drive(1, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_alu_op", 32'(alu_op), 32'd0);
    check_eq("ar_alu_in1", alu_in1, 32'd0);
    check_eq("ar_alu_in2", alu_in2, 32'd0);
    check_eq("ar_resp_data", resp_data, 32'd0);
    check_eq("ar_resp_tag", 32'(resp_tag), 32'd0);
    check_eq("ar_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_idle_resp(12, seen);
    check_eq("ar_lost_op", 32'(seen), 32'd0);

    // Fresh reset so the pointer starts at 0, then both ports contend continuously.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 6'd0, 32'd1, 32'd1, 4'd1);
    drive(1, 1'b1, 6'd0, 32'd2, 32'd2, 4'd2);
    grants = 0; r0 = 0; r1 = 0; both_hi = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready && req1_ready) both_hi++;
      if (req0_ready || req1_ready) begin
        check_eq("rr_grant_port", 32'(req1_ready), 32'(grants % 2));
        grants++;
      end
      if (resp_valid && resp_ready) begin
        if (resp_src) begin
          r1++;
          check_eq("rr_data1", resp_data, 32'd4);
        end else begin
          r0++;
          check_eq("rr_data0", resp_data, 32'd2);
        end
      end
      @(negedge clk);
    end
    drive(0, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
    check_eq("rr_grants", 32'(grants), 32'd4);
    check_eq("rr_resp0", 32'(r0), 32'd2);
    check_eq("rr_resp1", 32'(r1), 32'd2);
    check_eq("rr_both_ready", 32'(both_hi), 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_sequencer.md
# alu_issue_sequencer

Sequences the shared combinational ALU (integer, multiply, divide) between two issue ports. Round-robin arbitration picks one request at a time. The block latches its operands and holds them on the ALU inputs for an op-class-dependent number of cycles, so the long mul/div paths are multicycle paths. It then captures the result and the divide error flag and returns them with the requester's tag over a valid/ready response channel. It sits between the issue stage and the ALU; writeback consumes the response.

## Interface
Parameters:
- TAG_W, 4, width of the request/response tag (ROB index)
- MUL_CYCLES, 2, cycles operands are held for multiply ops (>=1)
- DIV_CYCLES, 8, cycles operands are held for divide/remainder ops (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- flush  in  1  cancel in-flight op, return to idle
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_aluop / req1_aluop  in  6  ALU opcode
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- req0_tag / req1_tag  in  TAG_W  requester tag
- alu_op  out  6  to ALU aluop
- alu_in1, alu_in2  out  32  to ALU operand inputs
- alu_out  in  32  ALU result
- alu_div_error  in  1  ALU divider error (divisor zero)
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  32  result
- resp_tag  out  TAG_W  tag of completed op
- resp_src  out  1  port that issued the op
- resp_div_error  out  1  op was div/divu/rem/remu with divisor zero

## Operation
- Latency class L is set by aluop[4:3]:
  - 0x → 1 (all single-cycle ops 0–9)
  - 10 → MUL_CYCLES (ops 16, 17, 18, 22)
  - 11 → DIV_CYCLES (ops 24, 26, 28, 30)
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE:
  - Arbiter grants one valid port. req*_ready is combinational: the grant, gated by IDLE and !flush.
  - On handshake, latch aluop/a/b/tag/src, load cnt=L-1, go to EXEC.
  - Round-robin pointer (reset 0) prefers port ptr. After a grant to port i, ptr becomes ~i. A lone valid port always wins.
- EXEC:
  - alu_op/alu_in1/alu_in2 drive the latched registers continuously, unchanged.
  - If cnt==0: capture the result, go to DONE. Otherwise cnt decrements.
- Result capture:
  - resp_div_error = alu_div_error AND aluop[4:3]==11.
  - If set, resp_data = 32'hFFFF_FFFF for div/divu (aluop[2]==0), or the latched operand a for rem/remu (aluop[2]==1).
  - Otherwise resp_data = alu_out.
- DONE:
  - resp_valid=1, and resp_* stay stable until resp_ready.
  - resp_valid & resp_ready → IDLE. The next request is accepted no earlier than the following cycle.
- flush, any state: next state IDLE, resp_valid low next cycle, ptr unchanged, no handshake in the flush cycle.
- In IDLE, ALU outputs hold their last latched values; the ALU result is ignored.

## Timing
- Reset values:
  - resp_valid, resp_data, resp_tag, resp_src, resp_div_error = 0
  - alu_op, alu_in1, alu_in2 = 0
  - cnt = 0, ptr = 0, state IDLE
  - req*_ready = 0 while rst_n low
- Define the accept edge as edge 0.
  - alu_* show the new op after edge 0.
  - The result is captured at edge L.
  - resp_valid is high from edge L.
- Cycles per op: L+1 plus backpressure cycles, plus 1 idle cycle before the next accept.
- Reset asserted mid-op: all state clears immediately (asynchronous). The op is lost; no response.
- Simultaneous flush and resp_ready in DONE: treat as flush (no difference in next state).
- Both ports valid in the same cycle: exactly one ready high; the other port holds its request.

## Structure
- Shared package/include `alu_pkg` holds:
  - opcode localparams (ALU_ADD=0 … ALU_REMU=30)
  - latency-class encodings
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, DONE=2'd2)
- One sub-module, `rr_arbiter2`: 2-way round-robin grant with pointer update on accept. Everything else sits in the top.

## Test plan
- Port 0 only, aluop=0, a=5, b=7 → resp_valid at edge 1, resp_data=12, resp_tag matches, resp_src=0.
- Port 1, aluop=22 (mul), a=6, b=7, MUL_CYCLES=2 → alu_in stable for 2 cycles, resp_data=42 at edge 2, resp_src=1.
- Both ports valid continuously with op 0, after reset → grants alternate 0,1,0,1; each port receives exactly one response per grant.
- Divisor zero:
  - aluop=24, a=100, b=0 → resp_div_error=1, resp_data=FFFF_FFFF.
  - aluop=28, a=100, b=0 → resp_div_error=1, resp_data=100.
- aluop=26, a=100, b=7, DIV_CYCLES=8, resp_ready held low 3 cycles after valid → resp_data=14 stable throughout, no new accept until the handshake.
- flush asserted in the 4th EXEC cycle of a divide → no response, IDLE next cycle, next request accepted and completes normally. A separate case: rst_n pulsed mid-EXEC → all outputs return to 0.
